// File: rtl/lcd_write_scheduler.sv
// Paced write scheduler for the character LCD: runs the power-on init sequence,
// then drains a byte FIFO, one LCD write per HD44780 execution time.
//
// Ports:
//   Clock, Reset_L             rising-edge clock, async active-low reset
//   wr_valid/wr_is_data/wr_byte   push strobe, cmd(0)/data(1), byte
//   flush                      synchronous FIFO clear, also clears overflow
//   wr_ready                   FIFO not full (registered)
//   status_out                 {level[11:8], ovf, init_done, busy, full, empty}
//   lcd_write_enable/lcd_cmd_or_data/lcd_data   write pulse and payload
module lcd_write_scheduler #(
    parameter int FIFO_DEPTH   = 8,
    parameter int POWERUP_WAIT = 2_500_000,
    parameter int SHORT_WAIT   = 2_000,
    parameter int LONG_WAIT    = 80_000
) (
    input  logic        Clock,
    input  logic        Reset_L,
    input  logic        wr_valid,
    input  logic        wr_is_data,
    input  logic [7:0]  wr_byte,
    input  logic        flush,
    output logic        wr_ready,
    output logic [31:0] status_out,
    output logic        lcd_write_enable,
    output logic        lcd_cmd_or_data,
    output logic [7:0]  lcd_data
);

    localparam int MAX_WAIT = (POWERUP_WAIT > LONG_WAIT) ? POWERUP_WAIT : LONG_WAIT;
    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    localparam logic [CW-1:0] PWR_CNT   = CW'(POWERUP_WAIT);
    localparam logic [CW-1:0] SHORT_CNT = CW'(SHORT_WAIT);
    localparam logic [CW-1:0] LONG_CNT  = CW'(LONG_WAIT);
    localparam logic [CW-1:0] SHORT_M1  = CW'((SHORT_WAIT > 0) ? SHORT_WAIT - 1 : 0);
    localparam logic [CW-1:0] LONG_M1   = CW'((LONG_WAIT > 0) ? LONG_WAIT - 1 : 0);
    localparam logic [LW-1:0] DEPTH     = LW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        PWR_WAIT,
        INIT_ISSUE,
        INIT_WAIT,
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      init_idx_q, init_idx_d;
    logic            init_done_q, init_done_d;

    logic [8:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   count_q, count_d;
    logic            ovf_q, ovf_d;

    logic            lcd_we_q, lcd_we_d;
    logic            lcd_cd_q, lcd_cd_d;
    logic [7:0]      lcd_data_q, lcd_data_d;
    logic            wr_ready_q, wr_ready_d;
    logic [31:0]     status_q, status_d;

    logic            full, empty, push, pop;
    logic            full_d, empty_d, busy_d;
    logic [8:0]      head;
    logic [7:0]      init_byte;

    // Clear-display and return-home need the long execution time
    function automatic logic is_long(input logic is_data, input logic [7:0] b);
        return !is_data && (b[7:2] == 6'd0);
    endfunction

    always_comb begin
        unique case (init_idx_q)
            2'd0:    init_byte = 8'h38;
            2'd1:    init_byte = 8'h0C;
            2'd2:    init_byte = 8'h01;
            default: init_byte = 8'h06;
        endcase
    end

    assign full  = (count_q == DEPTH);
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];
    // Fullness is judged before any same-edge pop; flush drops the push
    assign push  = wr_valid && !flush && !full;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_idx_d  = init_idx_q;
        init_done_d = init_done_q;
        lcd_we_d    = 1'b0;
        lcd_cd_d    = lcd_cd_q;
        lcd_data_d  = lcd_data_q;
        pop         = 1'b0;

        unique case (state_q)
            PWR_WAIT: begin
                if (cnt_q == '0) state_d = INIT_ISSUE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            INIT_ISSUE: begin
                lcd_we_d   = 1'b1;
                lcd_cd_d   = 1'b0;
                lcd_data_d = init_byte;
                // Pulse cycle plus W idle cycles before the next issue
                cnt_d      = is_long(1'b0, init_byte) ? LONG_CNT : SHORT_CNT;
                state_d    = INIT_WAIT;
            end
            INIT_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (init_idx_q == 2'd3) begin
                    init_done_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    init_idx_d = init_idx_q + 2'd1;
                    state_d    = INIT_ISSUE;
                end
            end
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    lcd_we_d   = 1'b1;
                    lcd_cd_d   = head[8];
                    lcd_data_d = head[7:0];
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                // The issued byte is held on the output regs; W cycles of WAIT
                cnt_d   = is_long(lcd_cd_q, lcd_data_q) ? LONG_M1 : SHORT_M1;
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q != '0) cnt_d   = cnt_q - 1'b1;
                else             state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + LW'(push) - LW'(pop);
        ovf_d    = ovf_q | (wr_valid && full);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
        end
        full_d     = (count_d == DEPTH);
        empty_d    = (count_d == '0);
        busy_d     = (state_d != IDLE) || !empty_d;
        wr_ready_d = !full_d;
        status_d   = {20'd0, 4'(count_d), 3'd0,
                      ovf_d, init_done_d, busy_d, full_d, empty_d};
    end

    always_ff @(posedge Clock) begin
        if (push) mem_q[wr_ptr_q] <= {wr_is_data, wr_byte};
    end

    always_ff @(posedge Clock or negedge Reset_L) begin
        if (!Reset_L) begin
            state_q     <= PWR_WAIT;
            cnt_q       <= PWR_CNT;
            init_idx_q  <= 2'd0;
            init_done_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            lcd_we_q    <= 1'b0;
            lcd_cd_q    <= 1'b0;
            lcd_data_q  <= 8'h00;
            wr_ready_q  <= 1'b1;
            status_q    <= 32'h0000_0001;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_idx_q  <= init_idx_d;
            init_done_q <= init_done_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            lcd_we_q    <= lcd_we_d;
            lcd_cd_q    <= lcd_cd_d;
            lcd_data_q  <= lcd_data_d;
            wr_ready_q  <= wr_ready_d;
            status_q    <= status_d;
        end
    end

    assign wr_ready         = wr_ready_q;
    assign status_out       = status_q;
    assign lcd_write_enable = lcd_we_q;
    assign lcd_cmd_or_data  = lcd_cd_q;
    assign lcd_data         = lcd_data_q;

endmodule

// File: tb/tb_lcd_write_scheduler.sv
// Directed bench for lcd_write_scheduler: init sequence, pacing, FIFO
// overflow, flush and mid-operation reset.
module tb_lcd_write_scheduler;

    logic        Clock;
    logic        Reset_L;
    logic        wr_valid;
    logic        wr_is_data;
    logic [7:0]  wr_byte;
    logic        flush;
    logic        wr_ready;
    logic [31:0] status_out;
    logic        lcd_write_enable;
    logic        lcd_cmd_or_data;
    logic [7:0]  lcd_data;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          pc[$];
    logic [8:0]  pd[$];

    lcd_write_scheduler #(
        .FIFO_DEPTH(4),
        .POWERUP_WAIT(10),
        .SHORT_WAIT(4),
        .LONG_WAIT(20)
    ) dut (
        .Clock(Clock),
        .Reset_L(Reset_L),
        .wr_valid(wr_valid),
        .wr_is_data(wr_is_data),
        .wr_byte(wr_byte),
        .flush(flush),
        .wr_ready(wr_ready),
        .status_out(status_out),
        .lcd_write_enable(lcd_write_enable),
        .lcd_cmd_or_data(lcd_cmd_or_data),
        .lcd_data(lcd_data)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    always @(posedge Clock) cyc <= cyc + 1;

    always @(negedge Clock) begin
        if (lcd_write_enable) begin
            pc.push_back(cyc);
            pd.push_back({lcd_cmd_or_data, lcd_data});
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int pcat(input int i);
        return (i < pc.size()) ? pc[i] : -1000;
    endfunction

    function automatic int pdat(input int i);
        return (i < pd.size()) ? int'(pd[i]) : -1;
    endfunction

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic clr();
        pc.delete();
        pd.delete();
    endtask

    task automatic check_init(input int r);
        int t;
        for (int i = 0; i < 200 && pc.size() < 4; i++) @(negedge Clock);
        chk("init_count", pc.size(), 4);
        chk("init_first", pcat(0) - r, 12);
        chk("init_gap0", pcat(1) - pcat(0), 6);
        chk("init_gap1", pcat(2) - pcat(1), 6);
        chk("init_gap2", pcat(3) - pcat(2), 22);
        chk("init_b0", pdat(0), 32'h038);
        chk("init_b1", pdat(1), 32'h00C);
        chk("init_b2", pdat(2), 32'h001);
        chk("init_b3", pdat(3), 32'h006);
        for (int i = 0; i < 100 && !status_out[3]; i++) @(negedge Clock);
        t = cyc;
        chk("init_done_at", t - pcat(3), 5);
        chk("init_status", status_out, 32'h9);
        chk("init_hold", 32'(lcd_data), 32'h06);
    endtask

    initial begin
        int r;
        int k;
        int nb;

        Reset_L    = 1'b0;
        wr_valid   = 1'b0;
        wr_is_data = 1'b0;
        wr_byte    = 8'h00;
        flush      = 1'b0;

        // Reset values and first init sequence
        repeat (3) step();
        chk("rst_we", 32'(lcd_write_enable), 0);
        chk("rst_cd", 32'(lcd_cmd_or_data), 0);
        chk("rst_data", 32'(lcd_data), 0);
        chk("rst_ready", 32'(wr_ready), 1);
        chk("rst_status", status_out, 32'h1);
        @(negedge Clock);
        clr();
        r = cyc;
        Reset_L = 1'b1;
        check_init(r);

        // Single data byte
        step();
        clr();
        wr_valid = 1'b1; wr_is_data = 1'b1; wr_byte = 8'h41;
        step();
        k = cyc;
        wr_valid = 1'b0;
        nb = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge Clock);
            if (status_out[2]) nb++;
        end
        chk("busy_cycles", nb, 6);
        chk("d41_count", pc.size(), 1);
        chk("d41_lat", pcat(0) - k, 1);
        chk("d41_byte", pdat(0), 32'h141);

        // Clear-home style command then data
        step();
        clr();
        wr_valid = 1'b1; wr_is_data = 1'b0; wr_byte = 8'h02;
        step();
        k = cyc;
        wr_is_data = 1'b1; wr_byte = 8'h48;
        step();
        wr_valid = 1'b0;
        repeat (40) step();
        chk("long_count", pc.size(), 2);
        chk("long_lat", pcat(0) - k, 1);
        chk("long_gap", pcat(1) - pcat(0), 22);
        chk("long_b0", pdat(0), 32'h002);
        chk("long_b1", pdat(1), 32'h148);

        // Overflow while busy
        step();
        clr();
        wr_valid = 1'b1; wr_is_data = 1'b1; wr_byte = 8'h55;
        step();
        k = cyc;
        for (int i = 0; i < 5; i++) begin
            wr_byte = 8'h10 + 8'(i);
            step();
            if (i == 2) chk("ready_lvl3", 32'(wr_ready), 1);
            if (i == 3) chk("ready_full", 32'(wr_ready), 0);
        end
        wr_valid = 1'b0;
        chk("ovf_status", status_out, 32'h41E);
        repeat (40) step();
        chk("ovf_count", pc.size(), 5);
        chk("ovf_lat", pcat(0) - k, 1);
        for (int j = 1; j < 5; j++) begin
            chk($sformatf("ovf_b%0d", j), pdat(j), 32'h110 + 32'(j - 1));
            chk($sformatf("ovf_gap%0d", j), pcat(j) - pcat(j - 1), 6);
        end
        chk("ovf_sticky", status_out, 32'h19);

        // Flush during the first wait, colliding with a push
        step();
        clr();
        wr_valid = 1'b1; wr_is_data = 1'b1; wr_byte = 8'h61;
        step();
        wr_byte = 8'h62;
        step();
        wr_byte = 8'h63;
        step();
        wr_valid = 1'b0;
        step();
        flush = 1'b1; wr_valid = 1'b1; wr_byte = 8'h77;
        step();
        flush = 1'b0; wr_valid = 1'b0;
        chk("flush_status", status_out, 32'h0D);
        repeat (40) step();
        chk("flush_count", pc.size(), 1);
        chk("flush_b0", pdat(0), 32'h161);
        chk("flush_idle", status_out, 32'h09);

        // Reset asserted mid-wait with bytes queued
        step();
        wr_valid = 1'b1; wr_is_data = 1'b1; wr_byte = 8'h70;
        step();
        wr_byte = 8'h71;
        step();
        wr_byte = 8'h72;
        step();
        wr_valid = 1'b0;
        step();
        Reset_L = 1'b0;
        #1;
        chk("mrst_we", 32'(lcd_write_enable), 0);
        chk("mrst_cd", 32'(lcd_cmd_or_data), 0);
        chk("mrst_data", 32'(lcd_data), 0);
        chk("mrst_ready", 32'(wr_ready), 1);
        chk("mrst_status", status_out, 32'h1);
        repeat (3) @(negedge Clock);
        clr();
        @(negedge Clock);
        r = cyc;
        Reset_L = 1'b1;
        check_init(r);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
